// File: rtl/iserdes_bitslip_ctrl.sv
// Word-alignment controller for an ISERDES2 deserializer (CLKDIV domain).
// Slips the word until TRAIN_PATTERN is seen LOCK_COUNT times, then watches for loss of lock.
module iserdes_bitslip_ctrl #(
   parameter int unsigned                DATA_WIDTH    = 4,
   parameter logic [DATA_WIDTH-1:0]      TRAIN_PATTERN = 4'b1100,
   parameter int unsigned                SETTLE_CYCLES = 3,
   parameter int unsigned                LOCK_COUNT    = 8,
   parameter int unsigned                MAX_SLIPS     = 3,
   parameter int unsigned                UNLOCK_THRESH = 4
) (
   input  logic                  clkdiv_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  data_valid_i,
   output logic                  bitslip_o,
   output logic                  busy_o,
   output logic                  locked_o,
   output logic                  error_o,
   output logic [3:0]            slip_count_o,
   output logic [2:0]            state_o
);

   generate
      if (DATA_WIDTH < 1 || DATA_WIDTH > 8 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 ||
          LOCK_COUNT < 1 || LOCK_COUNT > 255 || MAX_SLIPS > 15 ||
          UNLOCK_THRESH < 1 || UNLOCK_THRESH > 15) begin : g_bad_param
         $error("iserdes_bitslip_ctrl: parameter out of range");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_CHECK  = 3'd2,
      S_SLIP   = 3'd3,
      S_LOCKED = 3'd4,
      S_FAIL   = 3'd5
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
   localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_THRESH - 1);
   localparam logic [3:0] SLIP_LIMIT  = 4'(MAX_SLIPS);

   state_t     state_q, state_d;
   logic [3:0] settle_q, settle_d;
   logic [7:0] match_q, match_d;
   logic [3:0] mism_q, mism_d;
   logic [3:0] slip_q, slip_d;
   logic       error_q, error_d;
   logic       bitslip_q, busy_q, locked_q;
   logic       word_ok;

   // data_valid_i qualifies data_i: a word is compared only in a cycle where it is high;
   // there is no backpressure, so every valid word is consumed in the cycle it appears.
   assign word_ok = (data_i == TRAIN_PATTERN);

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      match_d  = match_q;
      mism_d   = mism_q;
      slip_d   = slip_q;
      error_d  = error_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d  = S_SETTLE;
               settle_d = 4'd0;
               match_d  = 8'd0;
               mism_d   = 4'd0;
               slip_d   = 4'd0;
               error_d  = 1'b0;
            end
         end
         S_SETTLE: begin
            match_d = 8'd0;
            if (settle_q == SETTLE_LAST) begin
               state_d  = S_CHECK;
               settle_d = 4'd0;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         S_CHECK: begin
            if (data_valid_i) begin
               if (word_ok) begin
                  if (match_q == LOCK_LAST) begin
                     state_d = S_LOCKED;
                     match_d = 8'd0;
                     mism_d  = 4'd0;
                  end else begin
                     match_d = match_q + 8'd1;
                  end
               end else begin
                  match_d = 8'd0;
                  if (slip_q < SLIP_LIMIT) begin
                     state_d = S_SLIP;
                     slip_d  = (slip_q == 4'hF) ? 4'hF : slip_q + 4'd1;
                  end else begin
                     state_d = S_FAIL;
                     error_d = 1'b1;
                  end
               end
            end
         end
         S_SLIP: begin
            state_d  = S_SETTLE;
            settle_d = 4'd0;
         end
         S_LOCKED: begin
            // A fresh START wins over a retrain triggered in the same cycle.
            if (start_i) begin
               state_d  = S_SETTLE;
               settle_d = 4'd0;
               mism_d   = 4'd0;
               slip_d   = 4'd0;
            end else if (data_valid_i) begin
               if (word_ok) begin
                  mism_d = 4'd0;
               end else if (mism_q == UNLOCK_LAST) begin
                  state_d  = S_SETTLE;
                  settle_d = 4'd0;
                  mism_d   = 4'd0;
                  slip_d   = 4'd0;
               end else begin
                  mism_d = mism_q + 4'd1;
               end
            end
         end
         S_FAIL: begin
            if (start_i) begin
               state_d  = S_SETTLE;
               settle_d = 4'd0;
               mism_d   = 4'd0;
               slip_d   = 4'd0;
               error_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clkdiv_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         settle_q  <= 4'd0;
         match_q   <= 8'd0;
         mism_q    <= 4'd0;
         slip_q    <= 4'd0;
         error_q   <= 1'b0;
         bitslip_q <= 1'b0;
         busy_q    <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         match_q   <= match_d;
         mism_q    <= mism_d;
         slip_q    <= slip_d;
         error_q   <= error_d;
         bitslip_q <= (state_d == S_SLIP);
         busy_q    <= (state_d == S_SETTLE) || (state_d == S_CHECK) || (state_d == S_SLIP);
         locked_q  <= (state_d == S_LOCKED);
      end
   end

   assign bitslip_o    = bitslip_q;
   assign busy_o       = busy_q;
   assign locked_o     = locked_q;
   assign error_o      = error_q;
   assign slip_count_o = slip_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_iserdes_bitslip_ctrl.sv
// Directed bench: stimulus pushes timed output-change events; a monitor pops and compares.
// Event vector = {bitslip, busy, locked, error, slip_count[3:0]}, tagged with the clock-edge number.
module tb_iserdes_bitslip_ctrl;

   localparam logic [3:0] PAT = 4'hC;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_i;
   logic       valid_i;
   logic [3:0] data_drv;
   logic [3:0] data_i;
   logic [3:0] model_data;
   logic       use_model;
   logic       rot_set;
   logic [1:0] rot;
   logic       bitslip_o, busy_o, locked_o, error_o;
   logic [3:0] slip_count_o;
   logic [2:0] state_o;

   int unsigned cyc = 0;
   int          tests = 0;
   int          fails = 0;
   logic        mon_en = 1'b0;
   logic [7:0]  prev_v;
   logic [39:0] exp_q[$];

   iserdes_bitslip_ctrl dut (
      .clkdiv_i     (clk),
      .rst_n_i      (rst_n),
      .start_i      (start_i),
      .data_i       (data_i),
      .data_valid_i (valid_i),
      .bitslip_o    (bitslip_o),
      .busy_o       (busy_o),
      .locked_o     (locked_o),
      .error_o      (error_o),
      .slip_count_o (slip_count_o),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ISERDES2: each BITSLIP rotates the word by one bit.
   always @(posedge clk) begin
      if (rot_set) rot <= 2'd2;
      else if (bitslip_o) rot <= rot + 2'd1;
   end

   always_comb begin
      model_data = PAT;
      case (rot)
         2'd0: model_data = 4'hC;
         2'd1: model_data = 4'h9;
         2'd2: model_data = 4'h3;
         2'd3: model_data = 4'h6;
         default: model_data = 4'hC;
      endcase
   end

   assign data_i = use_model ? model_data : data_drv;

   task automatic drive(input logic st, input logic vld, input logic [3:0] d);
      @(posedge clk);
      #1;
      start_i  = st;
      valid_i  = vld;
      data_drv = d;
   endtask

   task automatic expect_ev(input int unsigned c, input logic [7:0] v);
      exp_q.push_back({c, v});
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %02h, want %02h", name, got, want);
      end
   endtask

   initial begin
      int unsigned s;
      int unsigned e1;
      logic [7:0]  v;
      logic [39:0] ev;

      rst_n     = 1'b0;
      start_i   = 1'b0;
      valid_i   = 1'b0;
      data_drv  = 4'h0;
      use_model = 1'b0;
      rot_set   = 1'b0;
      prev_v    = 8'h00;

      fork
         forever begin
            @(negedge clk);
            if (mon_en) begin
               v = {bitslip_o, busy_o, locked_o, error_o, slip_count_o};
               if (v !== prev_v) begin
                  tests++;
                  if (exp_q.size() == 0) begin
                     fails++;
                     $display("FAIL unexpected_event: got cyc=%0d v=%02h, want no change", cyc, v);
                  end else begin
                     ev = exp_q.pop_front();
                     if (ev[39:8] != cyc || ev[7:0] !== v) begin
                        fails++;
                        $display("FAIL event: got cyc=%0d v=%02h, want cyc=%0d v=%02h",
                                 cyc, v, ev[39:8], ev[7:0]);
                     end
                  end
                  prev_v = v;
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {bitslip_o, busy_o, locked_o, error_o, slip_count_o}, 8'h00);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // 1: already aligned
      drive(1'b1, 1'b1, PAT);
      s = cyc + 1;
      expect_ev(s, 8'h40);
      expect_ev(s + 11, 8'h20);
      repeat (14) drive(1'b0, 1'b1, PAT);

      // 2: word starts two bits off, needs two slips
      rot_set = 1'b1;
      drive(1'b0, 1'b0, PAT);
      rot_set   = 1'b0;
      use_model = 1'b1;
      drive(1'b1, 1'b1, PAT);
      s = cyc + 1;
      expect_ev(s, 8'h40);
      expect_ev(s + 4, 8'hC1);
      expect_ev(s + 5, 8'h41);
      expect_ev(s + 9, 8'hC2);
      expect_ev(s + 10, 8'h42);
      expect_ev(s + 21, 8'h22);
      repeat (24) drive(1'b0, 1'b1, PAT);
      check("slips_after_lock", {4'h0, slip_count_o}, 8'h02);

      // 5: loss of lock, 3 bad / 1 good / 4 bad
      use_model = 1'b0;
      drive(1'b0, 1'b1, 4'h5);
      e1 = cyc + 1;
      expect_ev(e1 + 7, 8'h40);
      expect_ev(e1 + 18, 8'h20);
      drive(1'b0, 1'b1, 4'h5);
      drive(1'b0, 1'b1, 4'h5);
      drive(1'b0, 1'b1, PAT);
      repeat (3) drive(1'b0, 1'b1, 4'h5);
      check("locked_after_3_bad", {7'h0, locked_o}, 8'h01);
      drive(1'b0, 1'b1, 4'h5);
      repeat (12) drive(1'b0, 1'b1, PAT);
      check("relock_slip_count", {4'h0, slip_count_o}, 8'h00);

      // 3: never aligns, then a START restarts training
      drive(1'b0, 1'b0, 4'h5);
      drive(1'b1, 1'b1, 4'h5);
      s = cyc + 1;
      expect_ev(s, 8'h40);
      expect_ev(s + 4, 8'hC1);
      expect_ev(s + 5, 8'h41);
      expect_ev(s + 9, 8'hC2);
      expect_ev(s + 10, 8'h42);
      expect_ev(s + 14, 8'hC3);
      expect_ev(s + 15, 8'h43);
      expect_ev(s + 19, 8'h13);
      repeat (24) drive(1'b0, 1'b1, 4'h5);
      check("fail_status", {1'b0, busy_o, error_o, 1'b0, slip_count_o}, 8'h23);
      drive(1'b1, 1'b1, PAT);
      s = cyc + 1;
      expect_ev(s, 8'h40);
      expect_ev(s + 11, 8'h20);
      repeat (14) drive(1'b0, 1'b1, PAT);

      // 4: valid every other cycle, garbage on the invalid cycles
      drive(1'b1, 1'b1, PAT);
      s = cyc + 1;
      expect_ev(s, 8'h40);
      expect_ev(s + 18, 8'h20);
      for (int j = 1; j <= 21; j++) begin
         if (j % 2 == 0) drive(1'b0, 1'b1, PAT);
         else drive(1'b0, 1'b0, 4'h5);
      end

      // 6: reset during the SLIP cycle
      drive(1'b1, 1'b1, 4'h5);
      s = cyc + 1;
      expect_ev(s, 8'h40);
      expect_ev(s + 4, 8'hC1);
      expect_ev(s + 5, 8'h00);
      repeat (4) drive(1'b0, 1'b1, 4'h5);
      @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("bitslip_async_drop", {7'h0, bitslip_o}, 8'h00);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (20) drive(1'b0, 1'b1, PAT);
      check("idle_after_reset", {bitslip_o, busy_o, locked_o, error_o, slip_count_o}, 8'h00);
      drive(1'b1, 1'b1, PAT);
      s = cyc + 1;
      expect_ev(s, 8'h40);
      expect_ev(s + 11, 8'h20);
      repeat (14) drive(1'b0, 1'b1, PAT);

      repeat (3) @(posedge clk);
      while (exp_q.size() > 0) begin
         ev = exp_q.pop_front();
         tests++;
         fails++;
         $display("FAIL missing_event: got none, want cyc=%0d v=%02h", ev[39:8], ev[7:0]);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/iserdes_bitslip_ctrl.md
Name: iserdes_bitslip_ctrl

Overview:
Word-alignment controller for an ISERDES2-based deserializer. It runs in the CLKDIV domain and watches the parallel word (Q4..Q1) during a link training phase. It issues single-cycle BITSLIP pulses until the word matches a known training pattern for LOCK_COUNT consecutive valid words. It then reports lock, monitors for loss of alignment, and retrains automatically when alignment is lost.

Parameters:
DATA_WIDTH, 4, deserialized word width {1..8}; matches the ISERDES2 DATA_WIDTH.
TRAIN_PATTERN, 4'b1100, expected aligned word, DATA_WIDTH bits.
SETTLE_CYCLES, 3, CLKDIV cycles to wait after start or after any BITSLIP before comparing (1..15).
LOCK_COUNT, 8, consecutive valid matches required to declare lock (1..255).
MAX_SLIPS, 3, BITSLIP pulses allowed per training attempt before failure (0..15).
UNLOCK_THRESH, 4, consecutive valid mismatches while locked that force retraining (1..15).

Ports:
CLKDIV  in  1  divided parallel clock; the only clock.
RST_N  in  1  asynchronous active-low reset.
START  in  1  training request; acted on only in IDLE, LOCKED or FAIL.
DATA  in  DATA_WIDTH  parallel word; bit0 = Q1, bit DATA_WIDTH-1 = Q(DATA_WIDTH).
DATA_VALID  in  1  DATA is a fresh word this cycle; compare only when high.
BITSLIP  out  1  registered one-cycle slip pulse to the ISERDES2.
BUSY  out  1  high in SETTLE, CHECK and SLIP.
LOCKED  out  1  alignment achieved.
ERROR  out  1  training failed; sticky until START or reset.
SLIP_COUNT  out  4  BITSLIP pulses issued in the current attempt.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE. BITSLIP, BUSY, LOCKED, ERROR = 0. SLIP_COUNT, settle counter, match counter and mismatch counter = 0. BITSLIP drops immediately, with no clock needed.
- All outputs are registered and decoded from the state and counters.
- States and transitions:
  - IDLE: START=1 -> SETTLE. Clears SLIP_COUNT, all counters and ERROR.
  - SETTLE: counts CLKDIV cycles regardless of DATA_VALID. After SETTLE_CYCLES cycles in SETTLE -> CHECK. Match counter is cleared on entry.
  - CHECK: cycles with DATA_VALID=0 hold every counter and stay in CHECK.
    - Valid word and DATA==TRAIN_PATTERN: match counter +1. When it reaches LOCK_COUNT -> LOCKED. LOCKED rises the cycle after the LOCK_COUNT-th match.
    - Valid word and mismatch: match counter cleared.
      - If SLIP_COUNT < MAX_SLIPS -> SLIP.
      - Otherwise -> FAIL.
  - SLIP: BITSLIP=1 for exactly this one cycle and SLIP_COUNT +1, then -> SETTLE unconditionally. Two BITSLIP pulses are always at least SETTLE_CYCLES+2 cycles apart.
  - LOCKED: LOCKED=1, BUSY=0.
    - Valid mismatch: mismatch counter +1. A valid match clears it.
    - Mismatch counter reaches UNLOCK_THRESH: LOCKED drops the next cycle, SLIP_COUNT clears, -> SETTLE. This is a retrain with no START needed.
    - START=1 -> SETTLE with SLIP_COUNT cleared. START takes priority over the mismatch check in the same cycle.
  - FAIL: ERROR=1, BUSY=0, SLIP_COUNT holds its final value. START=1 -> SETTLE, ERROR cleared and SLIP_COUNT cleared.
- START is ignored while BUSY=1.
- SLIP_COUNT saturates at 15 and never wraps.
- Parameter limits: MAX_SLIPS=0 means the first mismatch goes straight to FAIL. LOCK_COUNT=1 means a single match locks.
- Counter widths: settle 4 bits, match 8 bits, mismatch 4 bits. Out-of-range parameter values are a synthesis/elaboration error, enforced by a generate-time check.

Test Plan:
All scenarios use the default parameters (DATA_WIDTH=4, TRAIN_PATTERN=4'hC, SETTLE_CYCLES=3, LOCK_COUNT=8, MAX_SLIPS=3, UNLOCK_THRESH=4).
1. Already aligned: pulse START, DATA=4'hC with DATA_VALID=1 every cycle -> BUSY for 3 settle cycles + 8 compare cycles; LOCKED=1 on the 12th cycle after START; BITSLIP never pulses; SLIP_COUNT=0.
2. Two slips needed: a behavioural ISERDES2 model rotates the word on each BITSLIP, starting 2 bits off -> exactly 2 single-cycle BITSLIP pulses ≥5 cycles apart; then LOCKED=1; SLIP_COUNT=2.
3. Never aligns: constant DATA=4'h5 -> 3 BITSLIP pulses, then ERROR=1, BUSY=0, SLIP_COUNT=3. A later START clears ERROR and restarts training.
4. Gapped valid: in CHECK, DATA_VALID toggles 1/0 with matching data -> lock takes 8 valid words (about 16 cycles); counters hold during invalid cycles.
5. Loss of lock: after lock, inject 3 mismatches, 1 match, then 4 mismatches -> LOCKED stays high through the first 3; it drops only after the 4th consecutive mismatch; the block re-enters SETTLE with SLIP_COUNT=0.
6. Reset mid-operation: assert RST_N=0 during the SLIP cycle -> BITSLIP falls with no clock edge; after release the state is IDLE with all outputs 0; START is required before training resumes.
